// File: rtl/axil_master_bridge.sv
// rtl/axil_master_bridge.sv - single-outstanding CPU request port to AXI4-Lite master bridge
module axil_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      aclk,
   input  logic                      arst_n,
   // CPU request / response port
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_timeout,
   output logic                      busy,
   // AXI4-Lite write channels
   output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
   output logic [2:0]                M_AXI_awprot,
   output logic                      M_AXI_awvalid,
   input  logic                      M_AXI_awready,
   output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
   output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
   output logic                      M_AXI_wvalid,
   input  logic                      M_AXI_wready,
   input  logic [1:0]                M_AXI_bresp,
   input  logic                      M_AXI_bvalid,
   output logic                      M_AXI_bready,
   // AXI4-Lite read channels
   output logic [ADDR_WIDTH-1:0]     M_AXI_araddr,
   output logic [2:0]                M_AXI_arprot,
   output logic                      M_AXI_arvalid,
   input  logic                      M_AXI_arready,
   input  logic [DATA_WIDTH-1:0]     M_AXI_rdata,
   input  logic [1:0]                M_AXI_rresp,
   input  logic                      M_AXI_rvalid,
   output logic                      M_AXI_rready
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_ADDR = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;
   localparam logic [2:0] S_DRAIN   = 3'd6;

   localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]     RESP_SLVERR = 2'b10;

   logic [2:0]                state;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH/8-1:0]   wstrb_q;
   logic                      op_write;
   logic                      pending_drain;
   logic [CW-1:0]             cnt;
   logic                      awvalid_q;
   logic                      wvalid_q;
   logic                      bready_q;
   logic                      arvalid_q;
   logic                      rready_q;
   logic                      aw_done;
   logic                      w_done;

   // A channel counts as done once its valid has been withdrawn after handshake,
   // or when the handshake is happening right now.
   assign aw_done = !awvalid_q || M_AXI_awready;
   assign w_done  = !wvalid_q  || M_AXI_wready;

   assign req_ready     = (state == S_IDLE);
   assign busy          = (state != S_IDLE);

   assign M_AXI_awaddr  = addr_q;
   assign M_AXI_araddr  = addr_q;
   assign M_AXI_wdata   = wdata_q;
   assign M_AXI_wstrb   = wstrb_q;
   assign M_AXI_awprot  = 3'b000;
   assign M_AXI_arprot  = 3'b000;
   assign M_AXI_awvalid = awvalid_q;
   assign M_AXI_wvalid  = wvalid_q;
   assign M_AXI_bready  = bready_q;
   assign M_AXI_arvalid = arvalid_q;
   assign M_AXI_rready  = rready_q;

   // Transaction sequencer: request capture, AXI handshakes, timeout and stale-response drain
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         state         <= S_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         op_write      <= 1'b0;
         pending_drain <= 1'b0;
         cnt           <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_timeout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q        <= req_addr;
                  wdata_q       <= req_wdata;
                  wstrb_q       <= req_wstrb;
                  op_write      <= req_write;
                  pending_drain <= 1'b0;
                  if (req_write) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state     <= S_WR;
                  end else begin
                     arvalid_q <= 1'b1;
                     state     <= S_RD_ADDR;
                  end
               end
            end

            S_WR: begin
               if (awvalid_q && M_AXI_awready) awvalid_q <= 1'b0;
               if (wvalid_q && M_AXI_wready)   wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_q <= 1'b1;
                  cnt      <= '0;
                  state    <= S_WR_RESP;
               end
            end

            S_WR_RESP: begin
               if (M_AXI_bvalid) begin
                  rsp_resp    <= M_AXI_bresp;
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  bready_q    <= 1'b0;
                  state       <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  rsp_resp      <= RESP_SLVERR;
                  rsp_rdata     <= '0;
                  rsp_timeout   <= 1'b1;
                  rsp_valid     <= 1'b1;
                  bready_q      <= 1'b0;
                  pending_drain <= 1'b1;
                  state         <= S_RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_RD_ADDR: begin
               if (M_AXI_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt       <= '0;
                  state     <= S_RD_DATA;
               end
            end

            S_RD_DATA: begin
               if (M_AXI_rvalid) begin
                  rsp_resp    <= M_AXI_rresp;
                  rsp_rdata   <= M_AXI_rdata;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rready_q    <= 1'b0;
                  state       <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  rsp_resp      <= RESP_SLVERR;
                  rsp_rdata     <= '0;
                  rsp_timeout   <= 1'b1;
                  rsp_valid     <= 1'b1;
                  rready_q      <= 1'b0;
                  pending_drain <= 1'b1;
                  state         <= S_RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (pending_drain) begin
                     // The slave still owes a response; soak it up before the next request.
                     if (op_write) bready_q <= 1'b1;
                     else          rready_q <= 1'b1;
                     state <= S_DRAIN;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            S_DRAIN: begin
               if ((op_write && M_AXI_bvalid) || (!op_write && M_AXI_rvalid)) begin
                  bready_q      <= 1'b0;
                  rready_q      <= 1'b0;
                  pending_drain <= 1'b0;
                  state         <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_master_bridge.sv
// tb/tb_axil_master_bridge.sv - self-checking bench for axil_master_bridge
module tb_axil_master_bridge;

   localparam int TO = 16;

   logic        aclk = 1'b0;
   logic        arst_n = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int tests = 0;
   int failed = 0;

   // slave behaviour knobs, written only by the stimulus block
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   bit          b_never = 1'b0, r_never = 1'b0;
   logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;

   // slave internal state, written only by the slave block
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit          aw_done, w_done, b_fire, ar_done, r_fire;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   logic [31:0] slave_mem [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];

   axil_master_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .aclk(aclk), .arst_n(arst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
      .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid),
      .M_AXI_awready(awready), .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb),
      .M_AXI_wvalid(wvalid), .M_AXI_wready(wready), .M_AXI_bresp(bresp),
      .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
      .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid),
      .M_AXI_arready(arready), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp),
      .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] v;
      v = old;
      for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      return v;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // AXI4-Lite memory slave; decisions made on the falling edge, away from the bridge's edge
   task automatic slave_step();
      logic [31:0] old;
      if (!arst_n) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
         bresp = 0; rresp = 0; rdata = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         aw_done = 0; w_done = 0; b_fire = 0; ar_done = 0; r_fire = 0;
         return;
      end
      if (awready) begin aw_done = 1; awready = 0; end
      else if (awvalid && !aw_done) begin
         if (aw_cnt >= aw_delay) begin awready = 1; s_awaddr = awaddr; end
         else aw_cnt++;
      end
      if (wready) begin w_done = 1; wready = 0; end
      else if (wvalid && !w_done) begin
         if (w_cnt >= w_delay) begin wready = 1; s_wdata = wdata; s_wstrb = wstrb; end
         else w_cnt++;
      end
      if (b_fire) begin
         if (bresp == 2'b00) begin
            old = slave_mem.exists(s_awaddr) ? slave_mem[s_awaddr] : init_word(s_awaddr);
            slave_mem[s_awaddr] = merge(old, s_wdata, s_wstrb);
         end
         bvalid = 0; b_fire = 0; aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
         if (!bvalid && aw_done && w_done && !b_never) begin
            if (b_cnt >= b_delay) begin bvalid = 1; bresp = b_resp_cfg; end
            else b_cnt++;
         end
         if (bvalid && bready) b_fire = 1;
      end
      if (arready) begin ar_done = 1; arready = 0; end
      else if (arvalid && !ar_done) begin
         if (ar_cnt >= ar_delay) begin arready = 1; s_araddr = araddr; end
         else ar_cnt++;
      end
      if (r_fire) begin
         rvalid = 0; r_fire = 0; ar_done = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
         if (!rvalid && ar_done && !r_never) begin
            if (r_cnt >= r_delay) begin
               rvalid = 1;
               rresp  = r_resp_cfg;
               if (r_resp_cfg == 2'b00)
                  rdata = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : init_word(s_araddr);
               else
                  rdata = 32'h0;
            end else r_cnt++;
         end
         if (rvalid && rready) r_fire = 1;
      end
   endtask

   initial begin
      forever begin
         @(negedge aclk);
         slave_step();
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic accept(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
      bit ok;
      ok = 0;
      req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1;
      for (int n = 0; n < 50 && !ok; n++) begin
         if (req_ready) ok = 1;
         tick();
      end
      req_valid = 0;
      chk("accept", ok, 1);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 200) begin
         tick();
         n++;
      end
      chk("rsp_wait", rsp_valid, 1);
   endtask

   task automatic take_rsp(input int hold);
      repeat (hold) tick();
      rsp_ready = 1;
      chk("no_bypass", req_ready, 0);
      tick();
      rsp_ready = 0;
   endtask

   initial begin
      int n;
      logic        w;
      logic [31:0] a, d, exp_data;
      logic [3:0]  s;
      logic [1:0]  code;

      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
      arst_n = 0;
      repeat (3) tick();
      chk("reset_ctrl", {req_ready, busy, awvalid, wvalid, arvalid, bready, rready,
                         rsp_valid, rsp_timeout}, 9'b1_0000_0000);
      chk("reset_data", {rsp_rdata, rsp_resp, awaddr[15:0], wstrb}, '0);
      arst_n = 1;
      tick();

      // zero-wait write: AW/W in cycle 1, bready cycle 2, rsp cycle 3
      accept(1, 32'h40, 32'hDEAD_BEEF, 4'hF);
      chk("wr1_c1_valid", {awvalid, wvalid, awaddr, wdata, wstrb, awprot, arprot},
          {2'b11, 32'h40, 32'hDEAD_BEEF, 4'hF, 6'b0});
      tick();
      chk("wr1_c2", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
      tick();
      chk("wr1_c3_rsp", {rsp_valid, rsp_resp, rsp_timeout, rsp_rdata}, {1'b1, 2'b00, 1'b0, 32'h0});
      take_rsp(0);
      chk("wr1_idle", {req_ready, busy}, 2'b10);
      ref_mem[32'h40] = 32'hDEAD_BEEF;

      // awready delayed 3 cycles, wready immediate
      aw_delay = 3;
      accept(1, 32'h40, 32'hDEAD_BEEF, 4'hF);
      chk("wr2_c1", {awvalid, wvalid}, 2'b11);
      for (int c = 2; c <= 4; c++) begin
         tick();
         chk($sformatf("wr2_c%0d", c), {awvalid, wvalid, bready, awaddr}, {3'b100, 32'h40});
      end
      tick();
      chk("wr2_c5", {awvalid, bready}, 2'b01);
      wait_rsp(n);
      chk("wr2_resp", {rsp_resp, rsp_timeout}, 3'b000);
      take_rsp(0);
      aw_delay = 0;

      // read with 2-cycle data delay, response held while rsp_ready low
      slave_mem[32'h104] = 32'h1234_5678;
      ref_mem[32'h104]   = 32'h1234_5678;
      r_delay = 2;
      accept(0, 32'h104, 32'h0, 4'h0);
      chk("rd1_ar", {arvalid, araddr}, {1'b1, 32'h104});
      wait_rsp(n);
      chk("rd1_latency", n, 4);
      chk("rd1_data", {rsp_rdata, rsp_resp, rsp_timeout}, {ref_word(32'h104), 2'b00, 1'b0});
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("rd1_hold", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, 32'h1234_5678, 2'b00});
      end
      take_rsp(0);
      r_delay = 0;

      // write timeout: slave never answers, then answers late and is drained
      b_never = 1;
      accept(1, 32'h80, 32'h0BAD_F00D, 4'hF);
      n = 0;
      while (!bready && n < 20) begin tick(); n++; end
      chk("to_bready", bready, 1);
      n = 0;
      while (!rsp_valid && n < 100) begin tick(); n++; end
      chk("to_latency", n, TO);
      chk("to_rsp", {rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, bready},
          {1'b1, 2'b10, 1'b1, 32'h0, 1'b0});
      take_rsp(0);
      chk("to_drain", {bready, req_ready, busy}, 3'b101);
      repeat (5) tick();
      chk("to_drain_wait", {req_ready, rsp_valid}, 2'b00);
      b_never = 0;
      n = 0;
      while (!req_ready && n < 20) begin tick(); n++; end
      chk("to_drain_done", n, 1);
      chk("to_after", {bready, rsp_valid, busy}, 3'b000);

      // DECERR read, then a normal read must still go through
      r_resp_cfg = 2'b11;
      accept(0, 32'h1000, 32'h0, 4'h0);
      wait_rsp(n);
      chk("decerr", {rsp_resp, rsp_timeout, rsp_rdata}, {2'b11, 1'b0, 32'h0});
      take_rsp(1);
      r_resp_cfg = 2'b00;
      accept(0, 32'h104, 32'h0, 4'h0);
      wait_rsp(n);
      chk("after_decerr", {rsp_resp, rsp_rdata}, {2'b00, 32'h1234_5678});
      take_rsp(0);

      // asynchronous reset while stalled in the write-address/data phase
      aw_delay = 5; w_delay = 5;
      accept(1, 32'h40, 32'h1111_2222, 4'h3);
      chk("rst_pre", {awvalid, wvalid, busy}, 3'b111);
      #2;
      arst_n = 0;
      #1;
      chk("rst_async", {awvalid, wvalid, busy, rsp_valid}, 4'b0000);
      tick();
      tick();
      arst_n = 1;
      aw_delay = 0; w_delay = 0;
      tick();
      chk("rst_release", {req_ready, busy}, 2'b10);

      // randomized traffic against the memory reference
      for (int t = 0; t < 24; t++) begin
         w = 1'($urandom_range(0, 1));
         a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         n = $urandom_range(0, 5);
         code = (n < 4) ? 2'b00 : (n == 4) ? 2'b10 : 2'b11;
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
         r_delay  = $urandom_range(0, 3);
         if (w) b_resp_cfg = code; else r_resp_cfg = code;
         exp_data = (w || code != 2'b00) ? 32'h0 : ref_word(a);
         accept(w, a, d, s);
         wait_rsp(n);
         chk($sformatf("rnd%0d_%s", t, w ? "wr" : "rd"), {rsp_resp, rsp_timeout, rsp_rdata},
             {code, 1'b0, exp_data});
         if (w && code == 2'b00) ref_mem[a] = merge(ref_word(a), d, s);
         take_rsp($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
